// File: rtl/vpe_pkg.sv
// Shared types and constants for the VPE result drain: result record layout,
// serializer states and the beat-count derivation.
package vpe_pkg;

  localparam int TILE_SIZE      = 128;
  localparam int ELEM_WIDTH     = 16;
  localparam int TAG_WIDTH      = 6;
  localparam int DEF_BEAT_ELEMS = 8;
  localparam int DEF_DEPTH      = 4;

  typedef struct packed {
    logic                            mode;
    logic [TAG_WIDTH-1:0]            tag;
    logic [ELEM_WIDTH-1:0]           scal;
    logic [TILE_SIZE*ELEM_WIDTH-1:0] vec;
  } vpe_result_t;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_e;

  function automatic int nbeats(input int tile, input int beat_elems);
    return tile / beat_elems;
  endfunction

endpackage

// File: rtl/vpe_result_drain_if.sv
// Signal bundle between the VPE result producer, the drain and the result-buffer sink.
// Valid/ready: a transfer occurs on a rising clk edge where valid && ready are both high;
// a sender that raises valid keeps valid and its payload unchanged until that transfer.
interface vpe_result_drain_if #(
  parameter int BEAT_ELEMS = vpe_pkg::DEF_BEAT_ELEMS
);
  import vpe_pkg::*;

  logic                                res_valid_i;
  logic                                res_ready_o;
  logic                                res_mode_i;
  logic [TILE_SIZE*ELEM_WIDTH-1:0]     res_vec_i;
  logic [ELEM_WIDTH-1:0]               res_scal_i;
  logic [TAG_WIDTH-1:0]                res_tag_i;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic [BEAT_ELEMS*ELEM_WIDTH-1:0]    out_data_o;
  logic [TAG_WIDTH-1:0]                out_tag_o;
  logic                                out_first_o;
  logic                                out_last_o;

  modport slave (
    input  res_valid_i, res_mode_i, res_vec_i, res_scal_i, res_tag_i, out_ready_i,
    output res_ready_o, out_valid_o, out_data_o, out_tag_o, out_first_o, out_last_o
  );

  modport master (
    output res_valid_i, res_mode_i, res_vec_i, res_scal_i, res_tag_i, out_ready_i,
    input  res_ready_o, out_valid_o, out_data_o, out_tag_o, out_first_o, out_last_o
  );

endinterface

// File: rtl/vpe_res_fifo.sv
// Synchronous FIFO of whole VPE results with a registered occupancy count.
// Same-cycle push and pop are allowed at any occupancy; pushing while full is not.
module vpe_res_fifo
  import vpe_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  vpe_result_t              din_i,
  output logic                     full_o,
  output logic                     empty_o,
  output vpe_result_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  vpe_result_t     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= din_i;
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/vpe_result_drain.sv
// Drain side of the VPE datapath: buffers wide tile results and serializes each
// into BEAT_ELEMS-element beats on a flow-controlled write stream.
module vpe_result_drain
  import vpe_pkg::*;
#(
  parameter int BEAT_ELEMS = DEF_BEAT_ELEMS,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  vpe_result_drain_if.slave     bus,
  output logic                  busy_o,
  output drain_state_e          dbg_state_o
);

  localparam int NBEATS = nbeats(TILE_SIZE, BEAT_ELEMS);
  localparam int BEAT_W = BEAT_ELEMS * ELEM_WIDTH;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  drain_state_e      r_state;
  drain_state_e      w_state_nxt;
  logic [BCW-1:0]    r_beat;
  logic [BCW-1:0]    w_beat_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_last;
  logic              w_stay;
  logic [CW-1:0]     w_count;
  vpe_result_t       w_in;
  vpe_result_t       w_head;
  logic [BEAT_W-1:0] w_vec_beats [NBEATS];

  assign w_in = '{mode: bus.res_mode_i, tag: bus.res_tag_i,
                  scal: bus.res_scal_i, vec: bus.res_vec_i};

  // Ready depends only on the registered count, never on the sink side.
  assign bus.res_ready_o = !w_full;
  assign w_push          = bus.res_valid_i && !w_full;

  vpe_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_in),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head),
    .count_o (w_count)
  );

  for (genvar g = 0; g < NBEATS; g++) begin : g_beat
    assign w_vec_beats[g] = w_head.vec[g*BEAT_W +: BEAT_W];
  end

  assign w_last = w_head.mode || (r_beat == BCW'(NBEATS - 1));
  // After popping the head, keep streaming if anything remains (including a same-cycle push).
  assign w_stay = (w_count != CW'(1)) || w_push;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = STREAM;
      end
      STREAM: begin
        if (bus.out_ready_i) begin
          if (w_last) begin
            w_pop      = 1'b1;
            w_beat_nxt = '0;
            if (!w_stay) w_state_nxt = IDLE;
          end else begin
            w_beat_nxt = r_beat + BCW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.out_valid_o = (r_state == STREAM);
  assign bus.out_data_o  = w_head.mode ? BEAT_W'(w_head.scal) : w_vec_beats[r_beat];
  assign bus.out_tag_o   = w_head.tag;
  assign bus.out_first_o = bus.out_valid_o && (w_head.mode || (r_beat == '0));
  assign bus.out_last_o  = bus.out_valid_o && w_last;

  assign busy_o      = !w_empty;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_vpe_result_drain.sv
// Bench for vpe_result_drain: table-driven single results, hand-written corner
// sequences and randomized traffic against a queue-based beat model.
module tb_vpe_result_drain;
  import vpe_pkg::*;

  localparam int BE = DEF_BEAT_ELEMS;
  localparam int BW = BE * ELEM_WIDTH;
  localparam int NB = TILE_SIZE / BE;
  localparam int VW = TILE_SIZE * ELEM_WIDTH;
  localparam int SW = TAG_WIDTH + 2 + BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  vpe_result_drain_if #(.BEAT_ELEMS(BE)) bus();
  logic         busy;
  drain_state_e dbg_state;

  vpe_result_drain #(.BEAT_ELEMS(BE), .DEPTH(DEF_DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .bus         (bus),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] log_q[$];
  int            cyc_q[$];
  logic [TAG_WIDTH-1:0] tag_q[$];
  int  outstanding = 0;
  int  mon_beat_idx = 0;
  int  stall_cnt = 0;
  bit  prev_stall = 1'b0;
  logic [SW-1:0] prev_beat;
  logic [SW-1:0] mon_act;
  logic [SW-1:0] mon_exp;

  int        rdy_mode = 0;     // 0 manual, 1 random, 2 fixed pattern
  logic      rdy_manual = 1'b1;
  logic [3:0] rdy_pat = 4'b1001;
  int        rdy_idx = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] pack_beat(input logic [TAG_WIDTH-1:0] tag,
                                              input logic first, input logic last,
                                              input logic [BW-1:0] data);
    return {tag, first, last, data};
  endfunction

  function automatic logic [VW-1:0] ramp_vec(input int base);
    logic [VW-1:0] v;
    for (int k = 0; k < TILE_SIZE; k++) v[k*ELEM_WIDTH +: ELEM_WIDTH] = 16'(base + k);
    return v;
  endfunction

  // Reference model: one accepted result expands into its list of beats.
  task automatic model_push(input logic mode, input logic [VW-1:0] vec,
                            input logic [ELEM_WIDTH-1:0] scal, input logic [TAG_WIDTH-1:0] tag);
    logic [BW-1:0] d;
    if (mode) begin
      d = '0;
      d[ELEM_WIDTH-1:0] = scal;
      exp_q.push_back(pack_beat(tag, 1'b1, 1'b1, d));
    end else begin
      for (int b = 0; b < NB; b++)
        exp_q.push_back(pack_beat(tag, b == 0, b == NB - 1, vec[b*BW +: BW]));
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst_i;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.out_ready_i = rdy_manual;
      1: bus.out_ready_i = ($urandom_range(0, 9) < 7);
      default: begin
        bus.out_ready_i = rdy_pat[rdy_idx];
        rdy_idx = (rdy_idx + 1) % 4;
      end
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_at_edge) begin
      exp_q.delete();
      outstanding  = 0;
      mon_beat_idx = 0;
      prev_stall   = 1'b0;
    end
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      mon_act = {bus.out_tag_o, bus.out_first_o, bus.out_last_o, bus.out_data_o};
      chk("busy", busy, outstanding != 0);
      chk("res_ready", bus.res_ready_o, outstanding != DEF_DEPTH);
      if (prev_stall) begin
        stall_cnt++;
        chk("stall_valid", bus.out_valid_o, 1);
        chk("stall_hold", mon_act, prev_beat);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat", mon_act, mon_exp);
          log_q.push_back(mon_act);
          cyc_q.push_back(cyc);
          if (mon_exp[BW]) begin
            outstanding--;
            mon_beat_idx = 0;
            tag_q.push_back(mon_act[SW-1 -: TAG_WIDTH]);
          end else begin
            mon_beat_idx++;
          end
        end
      end
      if (bus.res_valid_i && bus.res_ready_o) begin
        model_push(bus.res_mode_i, bus.res_vec_i, bus.res_scal_i, bus.res_tag_i);
        outstanding++;
      end
      prev_stall = bus.out_valid_o && !bus.out_ready_i;
      prev_beat  = mon_act;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic push_res(input logic mode, input logic [VW-1:0] vec,
                          input logic [ELEM_WIDTH-1:0] scal, input logic [TAG_WIDTH-1:0] tag);
    bit done = 1'b0;
    bus.res_valid_i = 1'b1;
    bus.res_mode_i  = mode;
    bus.res_vec_i   = vec;
    bus.res_scal_i  = scal;
    bus.res_tag_i   = tag;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = bus.res_ready_o;
      @(posedge clk);
      #1;
    end
    bus.res_valid_i = 1'b0;
    chk("push_accept", done, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy && (exp_q.size() == 0);
    end
    chk("drain_idle", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int mode, input logic manual);
    rdy_mode   = mode;
    rdy_manual = manual;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic                  mode;
    logic [ELEM_WIDTH-1:0] scal;
    logic [TAG_WIDTH-1:0]  tag;
    int                    vbase;
    int                    exp_beats;
    logic [BW-1:0]         exp_first;
    logic [BW-1:0]         exp_last;
  } vec_row_t;

  vec_row_t rows [4];

  initial begin : main
    int s0;
    int d0;
    logic [VW-1:0] rv;

    rows[0] = '{1'b1, 16'h3C00, 6'd5,  32'h55,  1,  128'h3C00, 128'h3C00};
    rows[1] = '{1'b0, 16'h0000, 6'd12, 32'h0,   16,
                128'h0007_0006_0005_0004_0003_0002_0001_0000,
                128'h007F_007E_007D_007C_007B_007A_0079_0078};
    rows[2] = '{1'b0, 16'h1234, 6'd63, 32'h100, 16,
                128'h0107_0106_0105_0104_0103_0102_0101_0100,
                128'h017F_017E_017D_017C_017B_017A_0179_0178};
    rows[3] = '{1'b1, 16'hFFFF, 6'd0,  32'h200, 1,  128'hFFFF, 128'hFFFF};

    bus.res_valid_i = 1'b0;
    bus.res_mode_i  = 1'b0;
    bus.res_vec_i   = '0;
    bus.res_scal_i  = '0;
    bus.res_tag_i   = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_first", bus.out_first_o, 0);
    chk("rst_last", bus.out_last_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_ready", bus.res_ready_o, 1);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;

    // Minimum latency: accepted at edge N, visible after edge N+1
    push_res(1'b1, '0, 16'h4400, 6'd3);
    @(negedge clk);
    chk("lat_n", bus.out_valid_o, 0);
    @(negedge clk);
    chk("lat_n1", bus.out_valid_o, 1);
    wait_idle(50);

    // Table-driven single results with the sink always ready
    for (int r = 0; r < 4; r++) begin
      s0 = log_q.size();
      push_res(rows[r].mode, ramp_vec(rows[r].vbase), rows[r].scal, rows[r].tag);
      wait_idle(100);
      chk("row_beats", log_q.size() - s0, rows[r].exp_beats);
      if (log_q.size() - s0 == rows[r].exp_beats) begin
        chk("row_first_data", log_q[s0][BW-1:0], rows[r].exp_first);
        chk("row_first_flag", log_q[s0][BW+1], 1);
        chk("row_last_data", log_q[s0+rows[r].exp_beats-1][BW-1:0], rows[r].exp_last);
        chk("row_last_flag", log_q[s0+rows[r].exp_beats-1][BW], 1);
        chk("row_tag", log_q[s0+rows[r].exp_beats-1][SW-1 -: TAG_WIDTH], rows[r].tag);
      end
      @(negedge clk);
      chk("row_after_valid", bus.out_valid_o, 0);
      chk("row_after_busy", busy, 0);
      @(posedge clk);
      #1;
    end

    // Backpressure with a 1,0,0,1 ready pattern
    set_ready(2, 1'b1);
    s0 = stall_cnt;
    d0 = log_q.size();
    push_res(1'b0, ramp_vec(0), '0, 6'd12);
    wait_idle(200);
    chk("bp_beats", log_q.size() - d0, NB);
    chk("bp_stalls_seen", (stall_cnt - s0) > 0, 1);

    // Full FIFO: 5 back-to-back pushes with the sink stalled
    set_ready(0, 1'b0);
    d0 = tag_q.size();
    for (int t = 1; t <= 4; t++) push_res(1'b0, ramp_vec(t * 16), '0, 6'(t));
    @(negedge clk);
    chk("full_res_ready", bus.res_ready_o, 0);
    @(posedge clk);
    #1;
    rdy_manual = 1'b1;
    push_res(1'b0, ramp_vec(80), '0, 6'd5);
    chk("full_tag5_after_pop", (tag_q.size() - d0) >= 1, 1);
    wait_idle(300);
    chk("full_results", tag_q.size() - d0, 5);
    if (tag_q.size() - d0 == 5)
      for (int t = 0; t < 5; t++) chk("full_tag_order", tag_q[d0+t], t + 1);

    // Back-to-back: two scalars then a vector, no bubbles
    s0 = log_q.size();
    push_res(1'b1, '0, 16'h1111, 6'd7);
    push_res(1'b1, '0, 16'h2222, 6'd8);
    push_res(1'b0, ramp_vec(32'h40), '0, 6'd9);
    wait_idle(100);
    chk("b2b_beats", log_q.size() - s0, NB + 2);
    if (log_q.size() - s0 == NB + 2)
      chk("b2b_no_bubble", cyc_q[s0+NB+1] - cyc_q[s0], NB + 1);

    // Reset during beat 7 of a vector with two results queued
    push_res(1'b0, ramp_vec(32'h300), '0, 6'd20);
    push_res(1'b1, '0, 16'hAAAA, 6'd21);
    push_res(1'b1, '0, 16'hBBBB, 6'd22);
    begin : wait_beat7
      bit hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
        if (mon_beat_idx == 7) hit = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      chk("rst_mid_reach_beat7", hit, 1);
    end
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", bus.out_valid_o, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_res_ready", bus.res_ready_o, 1);
    @(posedge clk);
    #1;
    s0 = log_q.size();
    push_res(1'b1, '0, 16'h5A5A, 6'd33);
    wait_idle(100);
    chk("rst_mid_new_beats", log_q.size() - s0, 1);
    if (log_q.size() - s0 == 1) begin
      chk("rst_mid_new_first", log_q[s0][BW+1], 1);
      chk("rst_mid_new_tag", log_q[s0][SW-1 -: TAG_WIDTH], 33);
      chk("rst_mid_new_data", log_q[s0][BW-1:0], 128'h5A5A);
    end

    // Randomized traffic with random sink stalls
    set_ready(1, 1'b1);
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      for (int w = 0; w < VW / 32; w++) rv[w*32 +: 32] = $urandom();
      push_res(1'($urandom_range(0, 1)), rv, 16'($urandom()), 6'($urandom_range(0, 63)));
    end
    wait_idle(3000);
    set_ready(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vpe_result_drain.md
Name: vpe_result_drain

Overview:
- Consumes one VPE tile result per handshake: either a TILE_SIZE-element vector or a scalar, selected by the same mode bit the tile used (1 = scalar, 0 = vector).
- Buffers results in a small FIFO.
- Serializes each result into fixed-width beats on a valid/ready write stream toward the result buffer.
- It is the drain side of the VPE datapath: the VPE produces wide results, and this block turns them into a narrow, flow-controlled stream.

Parameters:
- TILE_SIZE, 128, elements per vector result.
- ELEM_WIDTH, 16, bits per element; fp16, fpnew_pkg::fp_width of format 2.
- BEAT_ELEMS, 8, elements per output beat. Must divide TILE_SIZE.
- DEPTH, 4, result FIFO entries. Power of two, ≥2.
- TAG_WIDTH, 6, result tag identifying lane/stage. Tag = i*PIPE_STAGE + j.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- res_valid_i  in  1  result present.
- res_ready_o  out  1  result accepted this cycle when valid && ready.
- res_mode_i  in  1  1 = scalar result, 0 = vector result.
- res_vec_i  in  TILE_SIZE*ELEM_WIDTH  vector result, element k at bits [k*ELEM_WIDTH +: ELEM_WIDTH].
- res_scal_i  in  ELEM_WIDTH  scalar result.
- res_tag_i  in  TAG_WIDTH  source tag.
- out_valid_o  out  1  beat present.
- out_ready_i  in  1  sink accepts beat.
- out_data_o  out  BEAT_ELEMS*ELEM_WIDTH  beat payload.
- out_tag_o  out  TAG_WIDTH  tag of the result being streamed.
- out_first_o  out  1  first beat of a result.
- out_last_o  out  1  last beat of a result.
- busy_o  out  1  FIFO non-empty.

Behaviour:
- Reset (rst_i high at a clk_i edge): FIFO count=0, pointers=0, beat counter=0.
  - Cycle after reset: out_valid_o=0, out_first_o/out_last_o=0, busy_o=0, res_ready_o=1.
  - out_data_o and out_tag_o don't-care while out_valid_o=0.
- Reset mid-stream discards all buffered results and any partial beat sequence. No further beats of the discarded results are emitted.
- Input side:
  - res_ready_o = (count != DEPTH), decoded from registered state only. No combinational path from out_ready_i.
  - Push on res_valid_i && res_ready_o. Entry stores {mode, vec, scal, tag}.
- FIFO:
  - Simultaneous push and final-beat pop in one cycle: count unchanged, pointers both advance.
  - When full, res_ready_o stays 0 in that cycle even if the head is completing. No bypass.
  - Pointers wrap modulo DEPTH.
- Serializer: two states, IDLE and STREAM, plus a beat counter b, 0..NBEATS-1, where NBEATS = TILE_SIZE/BEAT_ELEMS.
  - IDLE: out_valid_o=0. Moves to STREAM on the edge after count becomes non-zero.
  - Minimum latency: a result accepted at edge N is first visible on out_valid_o in the cycle after edge N+1.
  - STREAM, head mode=0 (vector): beat b carries elements b*BEAT_ELEMS .. b*BEAT_ELEMS+BEAT_ELEMS-1, element 0 of the beat in the LSBs.
    - out_first_o = (b==0); out_last_o = (b==NBEATS-1).
  - STREAM, head mode=1 (scalar): exactly one beat. out_data_o = zero-extended res_scal; out_first_o = out_last_o = 1.
  - Beat accepted when out_valid_o && out_ready_i. Non-last beat: b increments.
  - Last beat accepted: pop head, b=0. If count after pop > 0, stay in STREAM and present the next head's first beat in the next cycle (no bubble). Otherwise go to IDLE.
  - While out_valid_o=1 and out_ready_i=0: out_data_o, out_tag_o, out_first_o and out_last_o hold stable.
  - out_valid_o never drops without acceptance.
- Ordering: results emerge in acceptance order. No element reordering or value modification.
- busy_o = (count != 0).

Decomposition:
- Package vpe_pkg:
  - TILE_SIZE and ELEM_WIDTH constants.
  - vpe_result_t packed struct {mode, tag, scal, vec}.
  - NBEATS derivation function.
  - Serializer state enum {IDLE, STREAM}.
- One sub-module: vpe_res_fifo, a synchronous FIFO of vpe_result_t.
  - Ports: push, pop, full, empty, head.
  - Registered count; same-cycle push+pop supported at any occupancy except push-when-full, which is forbidden.
- Serializer FSM, beat counter and beat mux live in vpe_result_drain.

Test Plan:
- Scalar: after reset, push mode=1, scal=16'h3C00, tag=5; out_ready_i=1 → exactly one beat: data=128'h3C00, tag=5, first=last=1. Then out_valid_o=0 and busy_o=0.
- Vector: push mode=0, vec element k = k, tag=12; out_ready_i=1 → 16 consecutive beats. Beat b element e = 8b+e. first only on beat 0, last only on beat 15, all beats carry tag 12.
- Backpressure: vector streaming, out_ready_i toggled 1,0,0,1,… → beat content held stable during stalls. Beat count and order are identical to the no-stall case.
- Full: DEPTH=4, out_ready_i=0, 5 back-to-back pushes (tags 1..5) → res_ready_o=0 after the 4th acceptance. Tag 5 is accepted only once the first result's last beat pops. Output tag order is 1,2,3,4,5.
- Back-to-back: two scalars then a vector, out_ready_i=1 → beats on consecutive cycles with no bubble between results. first/last correct per result.
- Reset mid-stream: assert rst_i during beat 7 of a vector with 2 more results queued → next cycle out_valid_o=0, busy_o=0, res_ready_o=1. A new scalar pushed afterwards streams normally with first=1.
